// File: rtl/pc_register.sv
// Program-counter and architectural-status register for the single-cycle Y86-64 core.
// Optional single-step control is compiled in with `define PC_SINGLE_STEP_EN.
module pc_register #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      nPC,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             start,
    input  logic             restart,
`ifdef PC_SINGLE_STEP_EN
    input  logic             step_mode,
    input  logic             step_req,
    output logic             step_ack,
`endif
    output logic [63:0]      PC,
    output logic [2:0]       stat,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

    state_t            state, state_nxt;
    logic [63:0]       pc_nxt;
    logic [2:0]        stat_nxt;
    logic [CNT_W-1:0]  cc_nxt, ic_nxt;
    logic              slot;
    logic              ack_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef PC_SINGLE_STEP_EN
    assign slot = !step_mode || step_req;
`else
    assign slot = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        stat_nxt  = stat;
        cc_nxt    = cycle_count;
        ic_nxt    = instr_count;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                cc_nxt = sat_inc(cycle_count);
                if (slot) begin
                    ack_nxt = 1'b1;
                    // Fault checks precede halt so a faulting halt never counts as retired.
                    if (imem_error) begin
                        stat_nxt  = STAT_ADR;
                        state_nxt = FAULT;
                    end else if (!instr_valid) begin
                        stat_nxt  = STAT_INS;
                        state_nxt = FAULT;
                    end else if (dmem_error) begin
                        stat_nxt  = STAT_ADR;
                        state_nxt = FAULT;
                    end else if (icode == 4'h0) begin
                        stat_nxt  = STAT_HLT;
                        state_nxt = HALTED;
                        ic_nxt    = sat_inc(instr_count);
                    end else begin
                        pc_nxt    = nPC;
                        ic_nxt    = sat_inc(instr_count);
                    end
                end
            end
            HALTED, FAULT: begin
                if (restart) begin
                    pc_nxt    = RESET_PC;
                    stat_nxt  = STAT_AOK;
                    cc_nxt    = '0;
                    ic_nxt    = '0;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef PC_SINGLE_STEP_EN
        if (!step_mode) ack_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            stat        <= STAT_AOK;
            running     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
`ifdef PC_SINGLE_STEP_EN
            step_ack    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            PC          <= pc_nxt;
            stat        <= stat_nxt;
            running     <= (state_nxt == RUN);
            cycle_count <= cc_nxt;
            instr_count <= ic_nxt;
`ifdef PC_SINGLE_STEP_EN
            step_ack    <= ack_nxt;
`endif
        end
    end

`ifndef PC_SINGLE_STEP_EN
    logic unused_ack;
    assign unused_ack = ack_nxt;
`endif

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: directed vector table, hand sequences and
// randomized stimulus against a behavioural model of the retire rules.
module tb_pc_register;

    localparam logic [63:0] RPC   = 64'h1000;
    localparam int          CW    = 4;
    localparam int          CMAX  = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   nPC = '0;
    logic [3:0]    icode = 4'h1;
    logic          instr_valid = 1'b1;
    logic          imem_error = 1'b0;
    logic          dmem_error = 1'b0;
    logic          start = 1'b0;
    logic          restart = 1'b0;
    logic [63:0]   PC;
    logic [2:0]    stat;
    logic          running;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instr_count;
`ifdef PC_SINGLE_STEP_EN
    logic          step_mode = 1'b0;
    logic          step_req = 1'b0;
    logic          step_ack;
`endif

    int checks = 0;
    int errors = 0;

    pc_register #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .nPC(nPC), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
        .start(start), .restart(restart),
`ifdef PC_SINGLE_STEP_EN
        .step_mode(step_mode), .step_req(step_req), .step_ack(step_ack),
`endif
        .PC(PC), .stat(stat), .running(running),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] e_pc, input int e_stat,
                           input int e_run, input int e_ic, input int e_cc);
        chk({tag, ".PC"}, PC, e_pc);
        chk({tag, ".stat"}, 64'(stat), 64'(e_stat));
        chk({tag, ".running"}, 64'(running), 64'(e_run));
        chk({tag, ".instr_count"}, 64'(instr_count), 64'(e_ic));
        chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(e_cc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: 0 idle, 1 run, 2 halted, 3 fault
    int          m_state;
    logic [63:0] m_pc;
    int          m_stat, m_ic, m_cc;

    task automatic model_reset();
        m_state = 0; m_pc = RPC; m_stat = 1; m_ic = 0; m_cc = 0;
    endtask

    task automatic model_edge();
        case (m_state)
            0: if (start) m_state = 1;
            1: begin
                m_cc = (m_cc + 1 > CMAX) ? CMAX : m_cc + 1;
                if (imem_error)        begin m_stat = 3; m_state = 3; end
                else if (!instr_valid) begin m_stat = 4; m_state = 3; end
                else if (dmem_error)   begin m_stat = 3; m_state = 3; end
                else begin
                    m_ic = (m_ic + 1 > CMAX) ? CMAX : m_ic + 1;
                    if (icode == 4'h0) begin m_stat = 2; m_state = 2; end
                    else m_pc = nPC;
                end
            end
            default: if (restart) begin
                m_pc = RPC; m_stat = 1; m_ic = 0; m_cc = 0; m_state = 1;
            end
        endcase
    endtask

    typedef struct {
        logic        st, rs, vld, ie, de;
        logic [3:0]  ic;
        logic [63:0] npc;
        logic [63:0] e_pc;
        int          e_stat, e_run, e_ic, e_cc;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic st, rs, vld, ie, de, input logic [3:0] ic,
                                input logic [63:0] npc, input logic [63:0] e_pc,
                                input int e_stat, e_run, e_ic, e_cc);
        vec_t v;
        v.st = st; v.rs = rs; v.vld = vld; v.ie = ie; v.de = de; v.ic = ic; v.npc = npc;
        v.e_pc = e_pc; v.e_stat = e_stat; v.e_run = e_run; v.e_ic = e_ic; v.e_cc = e_cc;
        return v;
    endfunction

    initial begin
        //            st rs vl ie de ic    npc        e_pc       st run ic cc
        tbl[0]  = mk(0, 1, 1, 0, 0, 4'h1, 64'h9999, RPC,        1, 0, 0, 0); // restart ignored in IDLE
        tbl[1]  = mk(1, 0, 1, 0, 0, 4'h1, 64'h9999, RPC,        1, 1, 0, 0); // start
        tbl[2]  = mk(0, 0, 1, 0, 0, 4'h1, 64'h1001, 64'h1001,   1, 1, 1, 1);
        tbl[3]  = mk(0, 0, 1, 0, 0, 4'h1, 64'h1002, 64'h1002,   1, 1, 2, 2);
        tbl[4]  = mk(0, 0, 1, 0, 0, 4'h1, 64'h0010, 64'h0010,   1, 1, 3, 3);
        tbl[5]  = mk(0, 0, 1, 0, 0, 4'h0, 64'h2000, 64'h0010,   2, 0, 4, 4); // halt
        tbl[6]  = mk(1, 0, 1, 0, 0, 4'h1, 64'h3000, 64'h0010,   2, 0, 4, 4); // start ignored
        tbl[7]  = mk(0, 1, 1, 0, 0, 4'h1, 64'h3000, RPC,        1, 1, 0, 0); // restart
        tbl[8]  = mk(0, 0, 1, 0, 0, 4'h1, 64'h0020, 64'h0020,   1, 1, 1, 1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 4'h0, 64'h4000, 64'h0020,   3, 0, 1, 2); // imem wins
        tbl[10] = mk(0, 1, 1, 0, 0, 4'h1, 64'h4000, RPC,        1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 4'h1, 64'h4000, RPC,        4, 0, 0, 1); // invalid
        tbl[12] = mk(0, 1, 1, 0, 0, 4'h1, 64'h4000, RPC,        1, 1, 0, 0);
        tbl[13] = mk(0, 0, 1, 0, 1, 4'h0, 64'h4000, RPC,        3, 0, 0, 1); // dmem beats halt
        tbl[14] = mk(0, 0, 0, 1, 1, 4'h0, 64'h5000, RPC,        3, 0, 0, 1); // frozen
        tbl[15] = mk(0, 1, 0, 1, 1, 4'h0, 64'h5000, RPC,        1, 1, 0, 0); // restart ignores errors

        #12;
        chk_all("reset", RPC, 1, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("idle_hold", RPC, 1, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].st; restart = tbl[i].rs; instr_valid = tbl[i].vld;
            imem_error = tbl[i].ie; dmem_error = tbl[i].de; icode = tbl[i].ic; nPC = tbl[i].npc;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_stat, tbl[i].e_run,
                    tbl[i].e_ic, tbl[i].e_cc);
        end
        start = 0; restart = 0; instr_valid = 1; imem_error = 0; dmem_error = 0; icode = 4'h1;

        // Counters saturate instead of wrapping
        for (int i = 0; i < 20; i++) begin
            nPC = 64'h40;
            tick();
        end
        chk_all("saturate", 64'h40, 1, 1, CMAX, CMAX);

        // Async reset between edges takes effect without a clock
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all("async_rst", RPC, 1, 0, 0, 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk_all("post_rst_idle", RPC, 1, 0, 0, 0);

`ifdef PC_SINGLE_STEP_EN
        step_mode = 1; step_req = 0; start = 1;
        tick();
        start = 0; nPC = 64'h55;
        chk("step.ack0", 64'(step_ack), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk_all("step.idle5", RPC, 1, 1, 0, 5);
        chk("step.noack", 64'(step_ack), 64'd0);
        step_req = 1;
        tick();
        step_req = 0;
        chk_all("step.one", 64'h55, 1, 1, 1, 6);
        chk("step.ack1", 64'(step_ack), 64'd1);
        tick();
        chk("step.ackdrop", 64'(step_ack), 64'd0);
        chk("step.hold", PC, 64'h55);
        step_mode = 0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
`endif

        // Randomized run against the model
        model_reset();
        for (int i = 0; i < 400; i++) begin
            start       = ($urandom % 2) == 0;
            restart     = ($urandom % 4) == 0;
            imem_error  = ($urandom % 16) == 0;
            instr_valid = ($urandom % 16) != 0;
            dmem_error  = ($urandom % 16) == 0;
            icode       = (($urandom % 8) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            nPC         = {$urandom, $urandom};
            tick();
            model_edge();
            chk_all($sformatf("rnd%0d", i), m_pc, m_stat, (m_state == 1) ? 1 : 0, m_ic, m_cc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
